instr_encoder: RTL and testbench

Encodes field-level instruction requests into 32-bit machine words in exactly the format the core's instruction decoder consumes: DP register/immediate, LDR/STR, B, MUL, the custom DIV, and FP add/mul. Sits between the test/boot loader and instruction memory. It accepts requests over a valid/ready handshake and rejects illegal field combinations. Legal words are buffered in a small FIFO and streamed into memory at auto-incrementing byte addresses.

---
 rtl/instr_encoder.sv | 158 +++++++++++++++
 tb/tb_instr_encoder.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: field-level instruction requests -> 32-bit machine words,
// buffered in a small FIFO and streamed to memory at rising byte addresses.
// Ports: CLK/RESETn, clear (sync flush), in_valid/in_ready + request fields,
// wr_valid/wr_ready/wr_addr/wr_data to memory, err pulse, err/word counters.
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0,
  parameter int DEPTH     = 2
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [3:0]        cond,
  input  logic [3:0]        opcode,
  input  logic              s,
  input  logic              ld,
  input  logic              up,
  input  logic              fp_mul,
  input  logic [3:0]        rn,
  input  logic [3:0]        rd,
  input  logic [3:0]        rm,
  input  logic [3:0]        rs,
  input  logic [23:0]       imm,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err,
  output logic [7:0]        err_count,
  output logic [15:0]       word_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    C_DPR = 3'd0,
    C_DPI = 3'd1,
    C_MEM = 3'd2,
    C_B   = 3'd3,
    C_MUL = 3'd4,
    C_DIV = 3'd5,
    C_FP  = 3'd6,
    C_RSV = 3'd7
  } cls_e;

  cls_e        cls;
  logic [31:0] word;
  logic        illegal;
  logic        dp_bad;
  logic        rd_pc;

  assign cls = cls_e'(in_class);
  // test/compare opcodes (1000-1011) only make sense with S set
  assign dp_bad = (opcode[3:2] == 2'b10) && !s;
  assign rd_pc  = (rd == 4'hF);

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    unique case (cls)
      C_DPR: begin
        word = {cond, 2'b00, 1'b0, opcode, s, rn, rd,
                imm[4:0], imm[6:5], 1'b0, rm};
        illegal = dp_bad;
      end
      C_DPI: begin
        word = {cond, 2'b00, 1'b1, opcode, s, rn, rd, imm[11:0]};
        illegal = dp_bad;
      end
      C_MEM: begin
        word = {cond, 2'b01, 1'b0, 1'b1, up, 1'b0, 1'b0, ld,
                rn, rd, imm[11:0]};
      end
      C_B: begin
        word = {cond, 4'b1010, imm};
      end
      C_MUL: begin
        word = {cond, 7'b0, s, rd, 4'b0000, rs, 4'b1001, rm};
        illegal = rd_pc;
      end
      C_DIV: begin
        word = {cond, 2'b01, 6'b111111, rd, 4'hF, rs, 4'hF, rm};
        illegal = rd_pc;
      end
      C_FP: begin
        word = {cond, 4'b1110, 1'b0, 1'b0, 1'b1, ~fp_mul,
                rn, rd, 4'b0000, 4'b0000, rm};
      end
      C_RSV: begin
        illegal = 1'b1;
      end
    endcase
  end

  logic [31:0] mem [DEPTH];
  logic [PW:0] wp;
  logic [PW:0] rp;
  logic        empty;
  logic        full;
  logic        acc;
  logic        push;
  logic        pop;

  assign empty = (wp == rp);
  assign full  = (wp[PW] != rp[PW]) &&
                 (wp[PW-1:0] == rp[PW-1:0]);

  // no pass-through: a full FIFO refuses even if it pops this cycle
  assign in_ready = !full && !clear;
  assign acc      = in_valid && in_ready;
  assign push     = acc && !illegal;
  assign pop      = !empty && wr_ready && !clear;

  assign wr_valid = !empty;
  assign wr_data  = empty ? 32'd0 : mem[rp[PW-1:0]];

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      wp         <= '0;
      rp         <= '0;
      wr_addr    <= BASE;
      err        <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
    end else if (clear) begin
      wp         <= '0;
      rp         <= '0;
      wr_addr    <= BASE;
      err        <= 1'b0;
      err_count  <= '0;
      word_count <= '0;
    end else begin
      if (push) begin
        wp <= wp + (PW+1)'(1);
      end
      if (pop) begin
        rp         <= rp + (PW+1)'(1);
        wr_addr    <= wr_addr + ADDR_W'(4);
        word_count <= word_count + 16'd1;
      end
      err <= acc && illegal;
      if (acc && illegal && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wp[PW-1:0]] <= word;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: random + directed stimulus, scoreboard queue of
// expected words checked by a monitor whenever a write is presented.
module tb_instr_encoder;

  typedef struct packed {
    logic [2:0]  cls;
    logic [3:0]  cnd;
    logic [3:0]  op;
    logic        sb;
    logic        ldb;
    logic        upb;
    logic        fm;
    logic [3:0]  n;
    logic [3:0]  d;
    logic [3:0]  m;
    logic [3:0]  t;
    logic [23:0] im;
  } req_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESETn, clear, in_valid, wr_ready;
  logic [2:0]  in_class;
  logic [3:0]  cond, opcode, rn, rd, rm, rs;
  logic        s, ld, up, fp_mul;
  logic [23:0] imm;
  logic        in_ready, wr_valid, err;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [7:0]  err_count;
  logic [15:0] word_count;

  logic        sm_clear, sm_in_valid, sm_wr_ready;
  logic        sm_in_ready, sm_wr_valid, sm_err;
  logic [3:0]  sm_wr_addr;
  logic [31:0] sm_wr_data;
  logic [7:0]  sm_err_count;
  logic [15:0] sm_word_count;

  instr_encoder #(.ADDR_W(10), .BASE_ADDR(0), .DEPTH(2)) u_dut (
    .CLK(CLK), .RESETn(RESETn), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_class(in_class), .cond(cond), .opcode(opcode), .s(s),
    .ld(ld), .up(up), .fp_mul(fp_mul),
    .rn(rn), .rd(rd), .rm(rm), .rs(rs), .imm(imm),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .err(err), .err_count(err_count), .word_count(word_count)
  );

  instr_encoder #(.ADDR_W(4), .BASE_ADDR(12), .DEPTH(2)) u_small (
    .CLK(CLK), .RESETn(RESETn), .clear(sm_clear),
    .in_valid(sm_in_valid), .in_ready(sm_in_ready),
    .in_class(in_class), .cond(cond), .opcode(opcode), .s(s),
    .ld(ld), .up(up), .fp_mul(fp_mul),
    .rn(rn), .rd(rd), .rm(rm), .rs(rs), .imm(imm),
    .wr_valid(sm_wr_valid), .wr_ready(sm_wr_ready),
    .wr_addr(sm_wr_addr), .wr_data(sm_wr_data),
    .err(sm_err), .err_count(sm_err_count),
    .word_count(sm_word_count)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic req_t mk(int c, int cn, int o, int sb, int ldb,
                              int upb, int fm, int n, int d, int m,
                              int t, int im);
    req_t r;
    r.cls = 3'(c);  r.cnd = 4'(cn); r.op = 4'(o);  r.sb = 1'(sb);
    r.ldb = 1'(ldb); r.upb = 1'(upb); r.fm = 1'(fm);
    r.n = 4'(n); r.d = 4'(d); r.m = 4'(m); r.t = 4'(t);
    r.im = 24'(im);
    return r;
  endfunction

  // reference encoder: each field shifted to its bit position
  function automatic logic [31:0] ref_word(req_t r);
    int unsigned c  = r.cnd;
    int unsigned o  = r.op;
    int unsigned sb = r.sb;
    int unsigned n  = r.n;
    int unsigned d  = r.d;
    int unsigned m  = r.m;
    int unsigned t  = r.t;
    int unsigned im = r.im;
    int unsigned w  = c << 28;
    case (r.cls)
      3'd0: w |= (o << 21) | (sb << 20) | (n << 16) | (d << 12)
               | ((im % 32) << 7) | (((im / 32) % 4) << 5) | m;
      3'd1: w |= (1 << 25) | (o << 21) | (sb << 20) | (n << 16)
               | (d << 12) | (im % 4096);
      3'd2: w |= (1 << 26) | (1 << 24) | (int'(r.upb) << 23)
               | (int'(r.ldb) << 20) | (n << 16) | (d << 12)
               | (im % 4096);
      3'd3: w |= (10 << 24) | im;
      3'd4: w |= (sb << 20) | (d << 16) | (t << 8) | (9 << 4) | m;
      3'd5: w |= (1 << 26) | (63 << 20) | (d << 16) | (15 << 12)
               | (t << 8) | (15 << 4) | m;
      3'd6: w |= (14 << 24) | (1 << 21) | ((r.fm ? 0 : 1) << 20)
               | (n << 16) | (d << 12) | m;
      default: w = 0;
    endcase
    return w;
  endfunction

  function automatic bit ref_illegal(req_t r);
    if (r.cls == 7) return 1;
    if (r.cls <= 1 && r.op >= 8 && r.op <= 11 && !r.sb) return 1;
    if ((r.cls == 4 || r.cls == 5) && r.d == 15) return 1;
    return 0;
  endfunction

  function automatic req_t cur_req();
    return mk(in_class, cond, opcode, s, ld, up, fp_mul,
              rn, rd, rm, rs, imm);
  endfunction

  task automatic set_req(req_t r);
    in_class = r.cls; cond = r.cnd; opcode = r.op; s = r.sb;
    ld = r.ldb; up = r.upb; fp_mul = r.fm;
    rn = r.n; rd = r.d; rm = r.m; rs = r.t; imm = r.im;
  endtask

  logic [31:0] exp_q[$];
  int unsigned exp_addr = 0;
  int unsigned exp_wc = 0;
  int unsigned exp_ec = 0;
  bit          err_due = 0;
  bit          dir_use = 0;
  logic [31:0] dir_word = 0;

  // input side: record accepted requests into the scoreboard
  always @(negedge CLK) begin
    #1;
    if (RESETn && in_valid && in_ready && !clear) begin
      if (ref_illegal(cur_req())) begin
        err_due = 1;
        if (exp_ec < 255) exp_ec++;
      end else begin
        exp_q.push_back(dir_use ? dir_word : ref_word(cur_req()));
      end
    end
  end

  // output side: compare what the DUT presents against the model
  always @(negedge CLK) begin
    if (!RESETn) begin
      exp_q.delete();
      exp_addr = 0; exp_wc = 0; exp_ec = 0; err_due = 0;
    end else begin
      check("err", err, err_due);
      err_due = 0;
      check("err_count", err_count, exp_ec);
      check("word_count", word_count, 16'(exp_wc));
      check("in_ready", in_ready, !clear && (exp_q.size() < 2));
      check("wr_valid", wr_valid, exp_q.size() != 0);
      if (wr_valid && exp_q.size() != 0) begin
        check("wr_data", wr_data, exp_q[0]);
        check("wr_addr", wr_addr, exp_addr);
      end
      if (clear) begin
        exp_q.delete();
        exp_addr = 0; exp_wc = 0; exp_ec = 0;
      end else if (wr_valid && wr_ready && exp_q.size() != 0) begin
        void'(exp_q.pop_front());
        exp_addr = (exp_addr + 4) % 1024;
        exp_wc++;
      end
    end
  end

  task automatic send(req_t r, bit use_dir, logic [31:0] dw);
    int n = 0;
    set_req(r);
    dir_use = use_dir;
    dir_word = dw;
    in_valid = 1;
    do begin
      @(negedge CLK);
      n++;
    end while (!in_ready && n < 100);
    check("accept_in_time", n < 100, 1);
    @(posedge CLK); #1;
    in_valid = 0;
    dir_use = 0;
  endtask

  task automatic reset_checks();
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_err", err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_word_count", word_count, 0);
    check("rst_sm_wr_addr", sm_wr_addr, 12);
  endtask

  task automatic do_reset();
    @(posedge CLK); #3;
    RESETn = 0;
    #1 reset_checks();
    @(negedge CLK); #2;
    RESETn = 1;
    @(posedge CLK); #1;
  endtask

  task automatic wait_cycles(int k);
    repeat (k) @(posedge CLK);
    #1;
  endtask

  initial begin
    req_t r;
    RESETn = 1; clear = 0; in_valid = 0; wr_ready = 0;
    sm_clear = 0; sm_in_valid = 0; sm_wr_ready = 0;
    set_req(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #2 RESETn = 0;
    #1 reset_checks();
    @(negedge CLK); #2;
    RESETn = 1;
    @(posedge CLK); #1;
    wr_ready = 1;

    send(mk(1, 14, 4, 0, 0, 0, 0, 2, 1, 0, 0, 5), 1, 32'hE2821005);
    wait_cycles(3);
    check("add_word_count", word_count, 1);

    do_reset();
    send(mk(2, 14, 0, 0, 1, 1, 0, 4, 3, 0, 0, 8), 1, 32'hE5943008);
    send(mk(2, 14, 0, 0, 0, 0, 0, 4, 3, 0, 0, 8), 1, 32'hE5043008);
    send(mk(4, 14, 0, 0, 0, 0, 0, 0, 5, 6, 7, 0), 1, 32'hE0050796);
    send(mk(5, 14, 0, 0, 0, 0, 0, 0, 5, 6, 7, 0), 1, 32'hE7F5F7F6);
    send(mk(6, 14, 0, 0, 0, 0, 0, 1, 2, 3, 0, 0), 1, 32'hEE312003);
    send(mk(3, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hFFFFFE), 1,
         32'hEAFFFFFE);
    wait_cycles(4);

    do_reset();
    send(mk(1, 14, 10, 0, 0, 0, 0, 1, 0, 0, 0, 3), 0, 0);
    send(mk(1, 14, 4, 0, 0, 0, 0, 2, 1, 0, 0, 5), 1, 32'hE2821005);
    wait_cycles(4);
    check("cmp_err_count", err_count, 1);
    check("cmp_word_count", word_count, 1);

    do_reset();
    wr_ready = 0;
    send(mk(1, 14, 4, 0, 0, 0, 0, 2, 1, 0, 0, 1), 0, 0);
    send(mk(1, 14, 4, 0, 0, 0, 0, 2, 1, 0, 0, 2), 0, 0);
    fork
      send(mk(1, 14, 4, 0, 0, 0, 0, 2, 1, 0, 0, 3), 0, 0);
      begin
        repeat (3) @(negedge CLK);
        check("full_in_ready", in_ready, 0);
        @(posedge CLK); #1;
        wr_ready = 1;
      end
    join
    wait_cycles(5);
    check("stall_word_count", word_count, 3);

    for (int i = 0; i < 400; i++) begin
      r = mk($urandom_range(0, 7), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 1), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom_range(0, 15),
             $urandom_range(0, 15), $urandom);
      set_req(r);
      in_valid = ($urandom_range(0, 3) != 0);
      wr_ready = ($urandom_range(0, 2) != 0);
      clear = ($urandom_range(0, 29) == 0);
      @(posedge CLK); #1;
    end
    clear = 0; in_valid = 0; wr_ready = 1;
    wait_cycles(4);

    do_reset();
    set_req(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    in_valid = 1;
    repeat (260) @(posedge CLK);
    #1 in_valid = 0;
    wait_cycles(2);
    check("err_count_sat", err_count, 255);

    wr_ready = 0;
    send(mk(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'h123456), 0, 0);
    send(mk(0, 2, 3, 1, 0, 0, 0, 4, 5, 6, 0, 'h7F), 0, 0);
    check("pre_reset_wr_valid", wr_valid, 1);
    do_reset();
    wr_ready = 1;
    wait_cycles(2);

    sm_wr_ready = 0;
    set_req(mk(1, 14, 4, 0, 0, 0, 0, 2, 1, 0, 0, 5));
    sm_in_valid = 1;
    @(posedge CLK); #1;
    set_req(mk(4, 14, 0, 0, 0, 0, 0, 0, 5, 6, 7, 0));
    @(posedge CLK); #1;
    sm_in_valid = 0;
    @(negedge CLK);
    check("sm_full_ready", sm_in_ready, 0);
    check("sm_addr0", sm_wr_addr, 12);
    check("sm_data0", sm_wr_data, 32'hE2821005);
    @(posedge CLK); #1;
    sm_wr_ready = 1;
    @(negedge CLK);
    check("sm_hold_addr", sm_wr_addr, 12);
    @(negedge CLK);
    check("sm_wrap_addr", sm_wr_addr, 0);
    check("sm_data1", sm_wr_data, 32'hE0050796);
    @(negedge CLK);
    check("sm_empty", sm_wr_valid, 0);
    check("sm_wc2", sm_word_count, 2);

    @(posedge CLK); #1;
    sm_wr_ready = 0;
    set_req(mk(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    sm_in_valid = 1;
    @(posedge CLK); #1;
    set_req(mk(1, 14, 4, 0, 0, 0, 0, 2, 1, 0, 0, 5));
    @(posedge CLK); #1;
    set_req(mk(4, 14, 0, 0, 0, 0, 0, 0, 5, 6, 7, 0));
    sm_clear = 1;
    sm_wr_ready = 1;
    @(negedge CLK);
    check("sm_pre_clr_ec", sm_err_count, 1);
    check("sm_pre_clr_valid", sm_wr_valid, 1);
    check("sm_pre_clr_addr", sm_wr_addr, 4);
    check("sm_clr_ready", sm_in_ready, 0);
    @(posedge CLK); #1;
    sm_clear = 0; sm_in_valid = 0; sm_wr_ready = 0;
    @(negedge CLK);
    check("sm_clr_valid", sm_wr_valid, 0);
    check("sm_clr_addr", sm_wr_addr, 12);
    check("sm_clr_wc", sm_word_count, 0);
    check("sm_clr_ec", sm_err_count, 0);
    check("sm_clr_err", sm_err, 0);
    @(posedge CLK); #1;
    set_req(mk(3, 14, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hFFFFFE));
    sm_in_valid = 1;
    @(posedge CLK); #1;
    sm_in_valid = 0;
    @(negedge CLK);
    check("sm_post_clr_valid", sm_wr_valid, 1);
    check("sm_post_clr_addr", sm_wr_addr, 12);
    check("sm_post_clr_data", sm_wr_data, 32'hEAFFFFFE);
    @(posedge CLK); #1;
    sm_wr_ready = 1;
    wait_cycles(3);
    check("sm_final_wc", sm_word_count, 1);

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge CLK);
    check("drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
